// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MIPS encodings for the EX-stage multiply/divide unit.
//                Holds the R-type func codes serviced by the HI/LO unit, the
//                ALU op class that qualifies the func field, and the
//                multiply/divide sequencer state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // R-type func field codes handled by the HI/LO unit
    localparam logic [5:0] FUNC_MFHI  = 6'h10;
    localparam logic [5:0] FUNC_MTHI  = 6'h11;
    localparam logic [5:0] FUNC_MFLO  = 6'h12;
    localparam logic [5:0] FUNC_MTLO  = 6'h13;
    localparam logic [5:0] FUNC_MULT  = 6'h18;
    localparam logic [5:0] FUNC_MULTU = 6'h19;
    localparam logic [5:0] FUNC_DIV   = 6'h1A;
    localparam logic [5:0] FUNC_DIVU  = 6'h1B;

    // alu_op class for which the func field is meaningful
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/muldiv_iter_core.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter_core
//  Description : Unsigned radix-2 iterative datapath. One shift-add multiply
//                step or one restoring-divide step per enabled cycle on a
//                2*XLEN accumulator. Sequencing and sign handling live in
//                the parent.
//  Ports       : clk, rst      - clock, async active-high reset
//                load          - capture operands and clear the accumulator
//                step          - perform one iteration
//                div_mode      - sampled on load: 1 = divide, 0 = multiply
//                opa           - multiplicand / dividend magnitude
//                opb           - multiplier / divisor magnitude
//                acc           - mul: {hi, lo} product
//                                div: {remainder, quotient}
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic              div_mode,
    input  logic [XLEN-1:0]   opa,
    input  logic [XLEN-1:0]   opb,
    output logic [2*XLEN-1:0] acc
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;   // multiplicand (mul) or divisor (div)
    logic              r_div;

    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_trial;
    logic [2*XLEN-1:0] w_acc_next;

    // Multiply: acc = {partial, multiplier}. Add the multiplicand into the
    // upper half when the current multiplier LSB is set, then shift right
    // bringing the carry in at the top.
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]}
                     + {1'b0, (r_acc[0] ? r_opnd : {XLEN{1'b0}})};

    // Divide: acc = {remainder, dividend}. Trial-subtract the divisor from
    // the remainder shifted left by one with the next dividend bit; bit XLEN
    // set means the trial went negative, so keep the plain shift.
    assign w_div_trial = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opnd};

    always_comb begin
        w_acc_next = r_acc;
        if (r_div) begin
            if (w_div_trial[XLEN]) begin
                w_acc_next = {r_acc[2*XLEN-2:0], 1'b0};
            end else begin
                w_acc_next = {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
            end
        end else begin
            w_acc_next = {w_mul_sum, r_acc[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_opnd <= '0;
            r_div  <= 1'b0;
        end else if (load) begin
            r_div  <= div_mode;
            r_opnd <= div_mode ? opb : opa;
            r_acc  <= {{XLEN{1'b0}}, (div_mode ? opa : opb)};
        end else if (step) begin
            r_acc  <= w_acc_next;
        end
    end

    assign acc = r_acc;

endmodule : muldiv_iter_core
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_unit
//  Description : EX-stage MIPS multiply/divide unit. Runs MULT/MULTU/DIV/DIVU
//                iteratively into architectural HI/LO, services MTHI/MTLO/
//                MFHI/MFLO and requests a pipeline stall when an md
//                instruction reaches ID/EX while an operation is in flight.
//  Ports       : clk, rst        - clock, async active-high reset
//                valid_idex      - ID/EX holds a real instruction
//                flush_ex        - squash the ID/EX instruction
//                alu_op_idex     - ALU op class
//                func_idex       - R-type func field
//                rs_data_idex    - rs operand
//                rt_data_idex    - rt operand
//                stall_md        - hold PC, IF/ID, ID/EX
//                busy            - operation in flight
//                hilo_sel        - EX result mux selects hilo_rdata
//                hilo_rdata      - HI (MFHI) / LO (MFLO) / 0
//                hi, lo          - architectural HI/LO
//                done            - one-cycle pulse: HI/LO just written
//                div_by_zero     - pulses with done when divisor was 0
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit
    import mips_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_idex,
    input  logic            flush_ex,
    input  logic [1:0]      alu_op_idex,
    input  logic [5:0]      func_idex,
    input  logic [XLEN-1:0] rs_data_idex,
    input  logic [XLEN-1:0] rt_data_idex,
    output logic            stall_md,
    output logic            busy,
    output logic            hilo_sel,
    output logic [XLEN-1:0] hilo_rdata,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            done,
    output logic            div_by_zero
);

    localparam int CW = $clog2(XLEN);

    md_state_t         r_state;
    md_state_t         w_state_next;
    logic [CW-1:0]     r_cnt;

    // Operation context captured at accept
    logic              r_is_div;
    logic              r_neg_q;      // negate product / quotient
    logic              r_neg_r;      // negate remainder (dividend sign)
    logic              r_div0;
    logic [XLEN-1:0]   r_rs_raw;

    logic              r_done;
    logic              r_div_by_zero;

    // Decode
    logic              w_rtype;
    logic              w_is_muldiv;
    logic              w_is_mthi;
    logic              w_is_mtlo;
    logic              w_is_mfhi;
    logic              w_is_mflo;
    logic              w_md_op;

    // Sequencer controls
    logic              w_accept;
    logic              w_step;
    logic              w_fix;

    // Operand magnitudes
    logic              w_signed;
    logic              w_rs_neg;
    logic              w_rt_neg;
    logic [XLEN-1:0]   w_rs_mag;
    logic [XLEN-1:0]   w_rt_mag;

    // Result path
    logic [2*XLEN-1:0] w_acc;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign w_rtype     = valid_idex & ~flush_ex & (alu_op_idex == ALUOP_RTYPE);
    assign w_is_muldiv = w_rtype & ((func_idex == FUNC_MULT) | (func_idex == FUNC_MULTU) |
                                    (func_idex == FUNC_DIV)  | (func_idex == FUNC_DIVU));
    assign w_is_mthi   = w_rtype & (func_idex == FUNC_MTHI);
    assign w_is_mtlo   = w_rtype & (func_idex == FUNC_MTLO);
    assign w_is_mfhi   = w_rtype & (func_idex == FUNC_MFHI);
    assign w_is_mflo   = w_rtype & (func_idex == FUNC_MFLO);
    assign w_md_op     = w_is_muldiv | w_is_mthi | w_is_mtlo | w_is_mfhi | w_is_mflo;

    assign busy     = (r_state != IDLE);
    assign stall_md = busy & w_md_op;
    assign hilo_sel = (w_is_mfhi | w_is_mflo) & ~busy;

    always_comb begin
        hilo_rdata = '0;
        if (w_is_mfhi) begin
            hilo_rdata = hi;
        end else if (w_is_mflo) begin
            hilo_rdata = lo;
        end
    end

    // ------------------------------------------------------------------
    // Operand magnitudes. func[0] = unsigned variant, func[1] = divide.
    // ------------------------------------------------------------------
    assign w_signed = ~func_idex[0];
    assign w_rs_neg = w_signed & rs_data_idex[XLEN-1];
    assign w_rt_neg = w_signed & rt_data_idex[XLEN-1];
    assign w_rs_mag = w_rs_neg ? -rs_data_idex : rs_data_idex;
    assign w_rt_mag = w_rt_neg ? -rt_data_idex : rt_data_idex;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_fix        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_is_muldiv) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_cnt == CW'(XLEN-1)) begin
                    w_state_next = FIX;
                end
            end
            FIX: begin
                w_fix        = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_rs_raw <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= func_idex[1];
            r_neg_q  <= w_rs_neg ^ w_rt_neg;
            r_neg_r  <= w_rs_neg;
            r_div0   <= (rt_data_idex == '0);
            r_rs_raw <= rs_data_idex;
        end else if (w_step) begin
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Iterative datapath
    // ------------------------------------------------------------------
    muldiv_iter_core #(
        .XLEN     (XLEN)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (w_accept),
        .step     (w_step),
        .div_mode (func_idex[1]),
        .opa      (w_rs_mag),
        .opb      (w_rt_mag),
        .acc      (w_acc)
    );

    // Sign correction. The signed-overflow case (most-negative / -1) needs
    // no special handling: the magnitude quotient 2^(XLEN-1) negates to
    // itself and the remainder is zero.
    assign w_prod_fix = r_neg_q ? -w_acc : w_acc;
    assign w_quo_fix  = r_neg_q ? -w_acc[XLEN-1:0]      : w_acc[XLEN-1:0];
    assign w_rem_fix  = r_neg_r ? -w_acc[2*XLEN-1:XLEN] : w_acc[2*XLEN-1:XLEN];

    // ------------------------------------------------------------------
    // HI/LO and completion flags. MTHI/MTLO only write while idle; held
    // under stall otherwise.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi            <= '0;
            lo            <= '0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done        <= w_fix;
            r_div_by_zero <= w_fix & r_is_div & r_div0;
            if (w_fix) begin
                if (r_is_div) begin
                    if (r_div0) begin
                        hi <= r_rs_raw;
                        lo <= '1;
                    end else begin
                        hi <= w_rem_fix;
                        lo <= w_quo_fix;
                    end
                end else begin
                    hi <= w_prod_fix[2*XLEN-1:XLEN];
                    lo <= w_prod_fix[XLEN-1:0];
                end
            end else if (r_state == IDLE) begin
                if (w_is_mthi) begin
                    hi <= rs_data_idex;
                end
                if (w_is_mtlo) begin
                    lo <= rs_data_idex;
                end
            end
        end
    end

    assign done        = r_done;
    assign div_by_zero = r_div_by_zero;

endmodule : ex_muldiv_unit
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_muldiv_unit
//  Description : Self-checking bench for ex_muldiv_unit. Table of mult/div
//                vectors with a result scoreboard, plus directed sequences
//                for reset, MTxx/MFxx, stall interaction and mid-op reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;
    import mips_pkg::*;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            valid_idex;
    logic            flush_ex;
    logic [1:0]      alu_op_idex;
    logic [5:0]      func_idex;
    logic [XLEN-1:0] rs_data_idex;
    logic [XLEN-1:0] rt_data_idex;
    logic            stall_md;
    logic            busy;
    logic            hilo_sel;
    logic [XLEN-1:0] hilo_rdata;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            done;
    logic            div_by_zero;

    ex_muldiv_unit #(
        .XLEN         (XLEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_idex   (valid_idex),
        .flush_ex     (flush_ex),
        .alu_op_idex  (alu_op_idex),
        .func_idex    (func_idex),
        .rs_data_idex (rs_data_idex),
        .rt_data_idex (rt_data_idex),
        .stall_md     (stall_md),
        .busy         (busy),
        .hilo_sel     (hilo_sel),
        .hilo_rdata   (hilo_rdata),
        .hi           (hi),
        .lo           (lo),
        .done         (done),
        .div_by_zero  (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]      func;
        logic [XLEN-1:0] rs;
        logic [XLEN-1:0] rt;
        logic [XLEN-1:0] exp_hi;
        logic [XLEN-1:0] exp_lo;
        logic            exp_dz;
    } vec_t;

    typedef struct {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
        logic            dz;
    } exp_t;

    localparam int NVEC = 11;
    vec_t vecs[NVEC];
    exp_t sbq[$];

    int n_vec;
    int n_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        valid_idex   = 1'b0;
        flush_ex     = 1'b0;
        alu_op_idex  = 2'b00;
        func_idex    = 6'h00;
        rs_data_idex = '0;
        rt_data_idex = '0;
    endtask

    // Called right after a negedge; returns right after the next negedge
    // with ID/EX emptied, i.e. just after the accept edge.
    task automatic issue(input logic [5:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        valid_idex   = 1'b1;
        flush_ex     = 1'b0;
        alu_op_idex  = ALUOP_RTYPE;
        func_idex    = f;
        rs_data_idex = a;
        rt_data_idex = b;
        @(negedge clk);
        drive_idle();
    endtask

    // Pop the oldest expectation and compare against the completed result.
    task automatic score(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: done with empty scoreboard", tag);
        end else begin
            e = sbq.pop_front();
            check({tag, " hi"}, 64'(hi), 64'(e.hi));
            check({tag, " lo"}, 64'(lo), 64'(e.lo));
            check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(e.dz));
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t  v;
        exp_t  e;
        int    lat;
        int    busy_n;
        string tag;
        v   = vecs[idx];
        tag = $sformatf("vec%0d", idx);
        e.hi = v.exp_hi;
        e.lo = v.exp_lo;
        e.dz = v.exp_dz;
        sbq.push_back(e);
        issue(v.func, v.rs, v.rt);
        lat    = 0;
        busy_n = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            lat++;
        end
        // done is seen XLEN+1 edges after the accept edge
        check({tag, " latency"}, 64'(lat), 64'(XLEN + 1));
        check({tag, " busy cycles"}, 64'(busy_n), 64'(XLEN + 1));
        if (done === 1'b1) begin
            score(tag);
        end else begin
            void'(sbq.pop_front());
        end
        @(negedge clk);
        check({tag, " done pulse width"}, 64'(done), 64'(0));
        // MFLO / MFHI read back the completed result combinationally
        valid_idex  = 1'b1;
        alu_op_idex = ALUOP_RTYPE;
        func_idex   = FUNC_MFLO;
        #1;
        check({tag, " mflo sel"}, 64'(hilo_sel), 64'(1));
        check({tag, " mflo data"}, 64'(hilo_rdata), 64'(v.exp_lo));
        func_idex = FUNC_MFHI;
        #1;
        check({tag, " mfhi data"}, 64'(hilo_rdata), 64'(v.exp_hi));
        drive_idle();
        #1;
    endtask

    initial begin
        int lat;
        int stalls;
        int dones;
        exp_t e;

        n_vec = 0;
        n_err = 0;

        vecs[0]  = '{FUNC_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
        vecs[1]  = '{FUNC_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[2]  = '{FUNC_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{FUNC_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
        vecs[4]  = '{FUNC_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5]  = '{FUNC_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[6]  = '{FUNC_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[7]  = '{FUNC_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[8]  = '{FUNC_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};
        vecs[9]  = '{FUNC_DIV,   32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
        vecs[10] = '{FUNC_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};

        // ---------------- reset state ----------------
        drive_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset div_by_zero", 64'(div_by_zero), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        // ---------------- MTHI / MTLO ----------------
        issue(FUNC_MTHI, 32'hAAAA_5555, 32'h0);
        check("mthi hi", 64'(hi), 64'(32'hAAAA_5555));
        check("mthi busy", 64'(busy), 64'(0));
        issue(FUNC_MTLO, 32'h0BAD_F00D, 32'h0);
        check("mtlo lo", 64'(lo), 64'(32'h0BAD_F00D));
        check("mtlo keeps hi", 64'(hi), 64'(32'hAAAA_5555));

        // ---------------- no-effect cases ----------------
        valid_idex = 1'b1; alu_op_idex = ALUOP_RTYPE; func_idex = FUNC_MULT; flush_ex = 1'b1;
        rs_data_idex = 32'd3; rt_data_idex = 32'd3;
        @(negedge clk);
        check("flushed mult busy", 64'(busy), 64'(0));
        flush_ex = 1'b0; valid_idex = 1'b0;
        @(negedge clk);
        check("bubble mult busy", 64'(busy), 64'(0));
        valid_idex = 1'b1; alu_op_idex = 2'b00;
        @(negedge clk);
        check("non-rtype busy", 64'(busy), 64'(0));
        func_idex = FUNC_MTLO; rs_data_idex = 32'h1111_1111;
        @(negedge clk);
        check("non-rtype mtlo lo", 64'(lo), 64'(32'h0BAD_F00D));
        drive_idle();
        @(negedge clk);

        // ---------------- table-driven mult/div ----------------
        for (int i = 0; i < NVEC; i++) begin
            run_vec(i);
        end

        // ---------------- MFLO held behind MULT ----------------
        @(negedge clk);
        e.hi = 32'h0; e.lo = 32'd42; e.dz = 1'b0;
        sbq.push_back(e);
        issue(FUNC_MULT, 32'd6, 32'd7);
        valid_idex  = 1'b1;
        alu_op_idex = ALUOP_RTYPE;
        func_idex   = FUNC_MFLO;
        lat    = 0;
        stalls = 0;
        #1;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 15) begin
                // an ordinary ALU instruction is not held while busy
                func_idex = 6'h20;
                #1;
                check("add during busy stall_md", 64'(stall_md), 64'(0));
                check("add during busy busy", 64'(busy), 64'(1));
                func_idex = FUNC_MFLO;
                #1;
            end
            if (stall_md === 1'b1) stalls++;
            @(negedge clk);
            #1;
            lat++;
        end
        check("mflo stall cycles", 64'(stalls), 64'(XLEN + 1));
        check("mflo done latency", 64'(lat), 64'(XLEN + 1));
        check("mflo stall at done", 64'(stall_md), 64'(0));
        check("mflo hilo_sel at done", 64'(hilo_sel), 64'(1));
        check("mflo rdata at done", 64'(hilo_rdata), 64'(42));
        if (done === 1'b1) begin
            score("mflo-seq");
        end else begin
            void'(sbq.pop_front());
        end
        drive_idle();
        #1;
        check("idle hilo_rdata", 64'(hilo_rdata), 64'(0));
        @(negedge clk);

        // ---------------- reset mid-operation ----------------
        issue(FUNC_MULT, 32'd3, 32'd5);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst busy", 64'(busy), 64'(0));
        check("midrst hi", 64'(hi), 64'(0));
        check("midrst lo", 64'(lo), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("midrst no done", 64'(dones), 64'(0));
        check("midrst lo stays 0", 64'(lo), 64'(0));
        issue(FUNC_MTLO, 32'h0000_1234, 32'h0);
        check("post-rst mtlo lo", 64'(lo), 64'(32'h0000_1234));

        check("scoreboard drained", 64'(sbq.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ex_muldiv_unit
`default_nettype wire
